// File: rtl/adder_result_fifo.sv
// Result collector for the non-stallable carry_pipe adder: tags each issued operand
// pair, captures the matching sum/carry PIPE_LAT edges later and serves it via valid/ready.
module adder_result_fifo #(
    parameter int WIDTH    = 32,
    parameter int PIPE_LAT = 2,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [WIDTH-1:0]         sum_in,
    input  logic                     cout_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PIPE_LAT-1:0] vpipe;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [WIDTH:0]      mem [DEPTH];
    logic [CW:0]         inflight;
    logic                accept;
    logic                push;
    logic                pop;

    // Credits cover both stored results and results still inside the adder, so a
    // capture can never find the FIFO full even though the adder cannot be stalled.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + {{CW{1'b0}}, vpipe[i]};
        end
        issue_ready = ({1'b0, count} + inflight) < (CW + 1)'(DEPTH);
    end

    assign accept    = issue_valid & issue_ready;
    assign push      = vpipe[PIPE_LAT-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_sum   = out_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
    assign out_cout  = out_valid ? mem[rd_ptr][WIDTH] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= accept;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cout_in, sum_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (issue_valid && !issue_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule
